// File: rtl/pipe_alu_pkg.sv
// Shared default widths and ALU function codes for the pipe_alu_regfile datapath.
package pipe_alu_pkg;

   localparam int unsigned DW_DEF   = 16;
   localparam int unsigned NREG_DEF = 16;
   localparam int unsigned AW_DEF   = 8;
   localparam int unsigned FW_DEF   = 4;

   localparam int unsigned FN_ADD   = 0;
   localparam int unsigned FN_SUB   = 1;
   localparam int unsigned FN_MUL   = 2;
   localparam int unsigned FN_PASSA = 3;
   localparam int unsigned FN_AND   = 4;
   localparam int unsigned FN_OR    = 5;
   localparam int unsigned FN_XOR   = 6;
   localparam int unsigned FN_NOTA  = 7;
   localparam int unsigned FN_SRL1  = 8;
   localparam int unsigned FN_SLL1  = 9;

endpackage

// File: rtl/pipe_alu.sv
// Combinational ALU: (A, B, func) -> DW-bit unsigned result.
// func 2 multiplies only when PIPE_ALU_MUL_EN is defined; otherwise it yields 0.
module pipe_alu
   import pipe_alu_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned FW = FW_DEF
)(
   input  logic [DW-1:0] i_a,
   input  logic [DW-1:0] i_b,
   input  logic [FW-1:0] i_func,
   output logic [DW-1:0] o_res
);

   always_comb begin
      o_res = '0;
      case (i_func)
         FW'(FN_ADD):   o_res = i_a + i_b;
         FW'(FN_SUB):   o_res = i_a - i_b;
`ifdef PIPE_ALU_MUL_EN
         FW'(FN_MUL):   o_res = i_a * i_b;
`else
         FW'(FN_MUL):   o_res = '0;
`endif
         FW'(FN_PASSA): o_res = i_a;
         FW'(FN_AND):   o_res = i_a & i_b;
         FW'(FN_OR):    o_res = i_a | i_b;
         FW'(FN_XOR):   o_res = i_a ^ i_b;
         FW'(FN_NOTA):  o_res = ~i_a;
         FW'(FN_SRL1):  o_res = i_a >> 1;
         FW'(FN_SLL1):  o_res = i_a << 1;
         default:       o_res = '0;
      endcase
   end

endmodule

// File: rtl/pipe_alu_regfile.sv
// 3-stage register-file ALU pipeline (fetch, execute, writeback) with full forwarding.
// Optional multiplier on func 2 is enabled by defining PIPE_ALU_MUL_EN.
module pipe_alu_regfile
   import pipe_alu_pkg::*;
#(
   parameter int unsigned DW   = DW_DEF,
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned AW   = AW_DEF,
   parameter int unsigned FW   = FW_DEF
)(
   input  logic                    CLK,
   input  logic                    RST_N,
   input  logic                    in_valid,
   input  logic [$clog2(NREG)-1:0] rs1,
   input  logic [$clog2(NREG)-1:0] rs2,
   input  logic [$clog2(NREG)-1:0] rd,
   input  logic [FW-1:0]           func,
   input  logic [AW-1:0]           addr,
   output logic                    out_valid,
   output logic [DW-1:0]           zout,
   input  logic [$clog2(NREG)-1:0] dbg_raddr,
   output logic [DW-1:0]           dbg_rdata,
   input  logic [AW-1:0]           mem_raddr,
   output logic [DW-1:0]           mem_rdata
);

   localparam int unsigned RW    = $clog2(NREG);
   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0] r_bank [NREG];
   logic [DW-1:0] r_mem  [DEPTH];

   logic          r_v1;
   logic [DW-1:0] r_a1;
   logic [DW-1:0] r_b1;
   logic [RW-1:0] r_rd1;
   logic [FW-1:0] r_func1;
   logic [AW-1:0] r_addr1;

   logic          r_v2;
   logic [DW-1:0] r_z2;
   logic [RW-1:0] r_rd2;
   logic [AW-1:0] r_addr2;

   logic [DW-1:0] w_alu;
   logic [DW-1:0] w_op_a;
   logic [DW-1:0] w_op_b;

   // Single ALU on the S1 registers feeds both the S2 capture and the distance-1 bypass.
   pipe_alu #(.DW(DW), .FW(FW)) u_alu (
      .i_a    (r_a1),
      .i_b    (r_b1),
      .i_func (r_func1),
      .o_res  (w_alu)
   );

   // Operand select: youngest valid producer wins, else the register bank.
   always_comb begin
      w_op_a = r_bank[rs1];
      w_op_b = r_bank[rs2];
      if (r_v1 && (rs1 == r_rd1))      w_op_a = w_alu;
      else if (r_v2 && (rs1 == r_rd2)) w_op_a = r_z2;
      if (r_v1 && (rs2 == r_rd1))      w_op_b = w_alu;
      else if (r_v2 && (rs2 == r_rd2)) w_op_b = r_z2;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_v1    <= 1'b0;
         r_a1    <= '0;
         r_b1    <= '0;
         r_rd1   <= '0;
         r_func1 <= '0;
         r_addr1 <= '0;
      end else begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_a1    <= w_op_a;
            r_b1    <= w_op_b;
            r_rd1   <= rd;
            r_func1 <= func;
            r_addr1 <= addr;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_v2    <= 1'b0;
         r_z2    <= '0;
         r_rd2   <= '0;
         r_addr2 <= '0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_z2    <= w_alu;
            r_rd2   <= r_rd1;
            r_addr2 <= r_addr1;
         end
      end
   end

   // Register bank comes out of reset holding its own indices.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < NREG; i++) r_bank[RW'(i)] <= DW'(i);
      end else if (r_v2) begin
         r_bank[r_rd2] <= r_z2;
      end
   end

   // Data memory has no reset; a flushed pipeline never presents r_v2.
   always_ff @(posedge CLK) begin
      if (r_v2) r_mem[r_addr2] <= r_z2;
   end

   assign out_valid = r_v2;
   assign zout      = r_z2;
   assign dbg_rdata = r_bank[dbg_raddr];
   assign mem_rdata = r_mem[mem_raddr];

endmodule

// File: tb/tb_pipe_alu_regfile.sv
// Bench for pipe_alu_regfile: directed scenarios and a random instruction stream
// compared against an in-order architectural model.
`timescale 1ns/1ps
module tb_pipe_alu_regfile;

   localparam int unsigned DW    = 16;
   localparam int unsigned NREG  = 16;
   localparam int unsigned AW    = 8;
   localparam int unsigned FW    = 4;
   localparam int unsigned RW    = 4;
   localparam int unsigned DEPTH = 256;
`ifdef PIPE_ALU_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   logic          CLK   = 1'b0;
   logic          RST_N = 1'b1;
   logic          in_valid = 1'b0;
   logic [RW-1:0] rs1 = '0, rs2 = '0, rd = '0, dbg_raddr = '0;
   logic [FW-1:0] func = '0;
   logic [AW-1:0] addr = '0, mem_raddr = '0;
   logic          out_valid;
   logic [DW-1:0] zout, dbg_rdata, mem_rdata;

   pipe_alu_regfile #(.DW(DW), .NREG(NREG), .AW(AW), .FW(FW)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .in_valid  (in_valid),
      .rs1       (rs1),
      .rs2       (rs2),
      .rd        (rd),
      .func      (func),
      .addr      (addr),
      .out_valid (out_valid),
      .zout      (zout),
      .dbg_raddr (dbg_raddr),
      .dbg_rdata (dbg_rdata),
      .mem_raddr (mem_raddr),
      .mem_rdata (mem_rdata)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      bit            v;
      int            rd;
      int            ad;
      logic [DW-1:0] res;
   } slot_t;

   logic [DW-1:0] s_reg [NREG];   // program-order view used to compute results
   logic [DW-1:0] a_reg [NREG];   // committed register state
   logic [DW-1:0] a_mem [DEPTH];
   bit            a_memv [DEPTH];
   slot_t         sl1, sl2;
   bit            exp_ov;
   logic [DW-1:0] exp_z;
   int            n_checks = 0;
   int            n_errors = 0;

   function automatic logic [DW-1:0] ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input int f);
      longint unsigned x, y, m, r;
      x = 64'(a);
      y = 64'(b);
      m = 64'd1 << DW;
      case (f)
         0:       r = (x + y) % m;
         1:       r = (x + m - y) % m;
         2:       r = MUL_ON ? (x * y) % m : 64'd0;
         3:       r = x;
         4:       r = x & y;
         5:       r = x | y;
         6:       r = x ^ y;
         7:       r = m - 1 - x;
         8:       r = x / 2;
         9:       r = (x * 2) % m;
         default: r = 64'd0;
      endcase
      return DW'(r);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         s_reg[i] = DW'(i);
         a_reg[i] = DW'(i);
      end
      sl1.v = 1'b0;
      sl2.v = 1'b0;
      exp_ov = 1'b0;
      exp_z  = '0;
   endtask

   // Drive one instruction slot, take one edge, advance the model, settle 1ns.
   task automatic cycle(input bit v, input int r1, input int r2, input int d,
                        input int f, input int ad);
      in_valid = v;
      rs1  = RW'(r1);
      rs2  = RW'(r2);
      rd   = RW'(d);
      func = FW'(f);
      addr = AW'(ad);
      @(posedge CLK);
      if (sl2.v) begin
         a_reg[sl2.rd]  = sl2.res;
         a_mem[sl2.ad]  = sl2.res;
         a_memv[sl2.ad] = 1'b1;
      end
      sl2 = sl1;
      exp_ov = sl1.v;
      if (sl1.v) exp_z = sl1.res;
      sl1.v  = v;
      sl1.rd = d;
      sl1.ad = ad;
      if (v) begin
         sl1.res  = ref_alu(s_reg[r1], s_reg[r2], f);
         s_reg[d] = sl1.res;
      end
      #1;
   endtask

   task automatic apply_reset();
      in_valid = 1'b0;
      RST_N = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic release_reset();
      @(negedge CLK);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (out_valid !== 1'b0 || zout !== '0) begin
         n_errors++;
         $display("FAIL reset_out: got v=%b z=%h, want v=0 z=0000", out_valid, zout);
      end
      for (int i = 0; i < NREG; i++) begin
         dbg_raddr = RW'(i);
         #1;
         n_checks++;
         if (dbg_rdata !== DW'(i)) begin
            n_errors++;
            $display("FAIL reset_bank[%0d]: got %h, want %h", i, dbg_rdata, DW'(i));
         end
      end
      release_reset();
   endtask

   task automatic test_add_latency();
      apply_reset();
      release_reset();
      dbg_raddr = RW'(10);
      mem_raddr = AW'(10);
      cycle(1, 3, 5, 10, 0, 10);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL add_edge1_valid: got %b, want 0", out_valid);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || zout !== 16'd8 || dbg_rdata !== 16'd10) begin
         n_errors++;
         $display("FAIL add_edge2: got v=%b z=%h r10=%h, want v=1 z=0008 r10=000a",
                  out_valid, zout, dbg_rdata);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b0 || dbg_rdata !== 16'd8 || mem_rdata !== 16'd8) begin
         n_errors++;
         $display("FAIL add_edge3: got v=%b r10=%h m10=%h, want v=0 r10=0008 m10=0008",
                  out_valid, dbg_rdata, mem_rdata);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      release_reset();
      dbg_raddr = RW'(2);
      cycle(1, 2, 3, 1, 0, 'h30);
      cycle(1, 1, 2, 2, 1, 'h31);
      n_checks++;
      if (out_valid !== 1'b1 || zout !== 16'd5) begin
         n_errors++;
         $display("FAIL b2b_first: got v=%b z=%h, want v=1 z=0005", out_valid, zout);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || zout !== 16'd3) begin
         n_errors++;
         $display("FAIL b2b_second: got v=%b z=%h, want v=1 z=0003", out_valid, zout);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (dbg_rdata !== 16'd3) begin
         n_errors++;
         $display("FAIL b2b_r2: got %h, want 0003", dbg_rdata);
      end
   endtask

   task automatic test_distance2();
      apply_reset();
      release_reset();
      cycle(1, 4, 4, 4, 0, 'h40);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 4, 6, 5, 6, 'h41);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL dist2_bubble_valid: got %b, want 0", out_valid);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || zout !== 16'd14) begin
         n_errors++;
         $display("FAIL dist2_xor: got v=%b z=%h, want v=1 z=000e", out_valid, zout);
      end
   endtask

   // Dependent chain builds r15=0x8001 then exercises wrap, shift-out and unused codes.
   task automatic test_wrap();
      int tbl [7][5] = '{
         '{0, 1, 7, 1, 'h60},     // SUB 0-1
         '{0, 0, 15, 7, 'h61},    // NOTA r0
         '{15, 0, 15, 8, 'h62},   // SRL1
         '{15, 1, 15, 6, 'h63},   // XOR r1
         '{15, 0, 15, 7, 'h64},   // NOTA -> 0x8001
         '{15, 0, 14, 9, 'h65},   // SLL1
         '{3, 5, 13, 12, 'h66}    // func 12
      };
      logic [DW-1:0] want [7] = '{16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFE,
                                  16'h8001, 16'h0002, 16'h0000};
      apply_reset();
      release_reset();
      for (int j = 0; j < 9; j++) begin
         if (j < 7) cycle(1, tbl[j][0], tbl[j][1], tbl[j][2], tbl[j][3], tbl[j][4]);
         else       cycle(0, 0, 0, 0, 0, 0);
         if (j >= 1 && j <= 7) begin
            n_checks++;
            if (out_valid !== 1'b1 || zout !== want[j-1]) begin
               n_errors++;
               $display("FAIL wrap_z[%0d]: got v=%b z=%h, want v=1 z=%h",
                        j - 1, out_valid, zout, want[j-1]);
            end
         end
      end
      cycle(0, 0, 0, 0, 0, 0);
      dbg_raddr = RW'(14);
      mem_raddr = AW'('h60);
      #1;
      n_checks++;
      if (dbg_rdata !== 16'h0002 || mem_rdata !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL wrap_state: got r14=%h m60=%h, want r14=0002 m60=ffff",
                  dbg_rdata, mem_rdata);
      end
      @(negedge CLK);
   endtask

   task automatic test_bubbles();
      logic [DW-1:0] snap [NREG];
      for (int k = 0; k < 3; k++) begin
         cycle(0, k, k, k, 0, k);
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bubble_valid[%0d]: got %b, want 0", k, out_valid);
         end
      end
      for (int i = 0; i < NREG; i++) begin
         dbg_raddr = RW'(i);
         #1;
         snap[i] = a_reg[i];
         n_checks++;
         if (dbg_rdata !== snap[i]) begin
            n_errors++;
            $display("FAIL bubble_bank[%0d]: got %h, want %h", i, dbg_rdata, snap[i]);
         end
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_flush();
      apply_reset();
      release_reset();
      cycle(1, 5, 6, 8, 0, 20);     // mem[20] = 11
      cycle(1, 7, 7, 9, 0, 21);     // mem[21] = 14
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 2, 0, 3, 3, 20);     // in flight, must not land
      cycle(1, 1, 0, 4, 7, 21);
      apply_reset();
      n_checks++;
      if (out_valid !== 1'b0 || zout !== '0) begin
         n_errors++;
         $display("FAIL flush_out: got v=%b z=%h, want v=0 z=0000", out_valid, zout);
      end
      release_reset();
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NREG; i++) begin
         dbg_raddr = RW'(i);
         #1;
         n_checks++;
         if (dbg_rdata !== DW'(i)) begin
            n_errors++;
            $display("FAIL flush_bank[%0d]: got %h, want %h", i, dbg_rdata, DW'(i));
         end
      end
      mem_raddr = AW'(20);
      #1;
      n_checks++;
      if (mem_rdata !== 16'd11) begin
         n_errors++;
         $display("FAIL flush_mem20: got %h, want 000b", mem_rdata);
      end
      mem_raddr = AW'(21);
      #1;
      n_checks++;
      if (mem_rdata !== 16'd14) begin
         n_errors++;
         $display("FAIL flush_mem21: got %h, want 000e", mem_rdata);
      end
      @(negedge CLK);
   endtask

   task automatic test_mul();
      logic [DW-1:0] want;
      want = MUL_ON ? 16'd63 : 16'd0;
      apply_reset();
      release_reset();
      dbg_raddr = RW'(2);
      cycle(1, 7, 9, 2, 2, 'h50);
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (out_valid !== 1'b1 || zout !== want) begin
         n_errors++;
         $display("FAIL mul_z: got v=%b z=%h, want v=1 z=%h", out_valid, zout, want);
      end
      cycle(0, 0, 0, 0, 0, 0);
      n_checks++;
      if (dbg_rdata !== want) begin
         n_errors++;
         $display("FAIL mul_r2: got %h, want %h", dbg_rdata, want);
      end
   endtask

   task automatic test_random();
      int r1, r2, d, f, ad, dr, hi;
      bit v;
      apply_reset();
      release_reset();
      for (int c = 0; c < 400; c++) begin
         hi = (c < 200) ? 3 : 15;
         v  = ($urandom_range(0, 3) != 0);
         r1 = $urandom_range(0, hi);
         r2 = $urandom_range(0, hi);
         d  = $urandom_range(0, hi);
         f  = $urandom_range(0, 15);
         ad = $urandom_range(0, 15);
         dr = $urandom_range(0, NREG - 1);
         dbg_raddr = RW'(dr);
         cycle(v, r1, r2, d, f, ad);
         n_checks++;
         if (out_valid !== exp_ov || (exp_ov && zout !== exp_z) || dbg_rdata !== a_reg[dr]) begin
            n_errors++;
            $display("FAIL rand_cyc[%0d]: got v=%b z=%h r%0d=%h, want v=%b z=%h r%0d=%h",
                     c, out_valid, zout, dr, dbg_rdata, exp_ov, exp_z, dr, a_reg[dr]);
         end
      end
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NREG; i++) begin
         dbg_raddr = RW'(i);
         #1;
         n_checks++;
         if (dbg_rdata !== a_reg[i]) begin
            n_errors++;
            $display("FAIL rand_bank[%0d]: got %h, want %h", i, dbg_rdata, a_reg[i]);
         end
      end
      for (int i = 0; i < 16; i++) begin
         if (a_memv[i]) begin
            mem_raddr = AW'(i);
            #1;
            n_checks++;
            if (mem_rdata !== a_mem[i]) begin
               n_errors++;
               $display("FAIL rand_mem[%0d]: got %h, want %h", i, mem_rdata, a_mem[i]);
            end
         end
      end
      @(negedge CLK);
   endtask

   initial begin
      #1;
      test_reset();
      test_add_latency();
      test_back_to_back();
      test_distance2();
      test_wrap();
      test_bubbles();
      test_reset_flush();
      test_mul();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule
